// File: rtl/rx_fifo.sv
// rx_fifo: byte FIFO between a UART receiver and a memory-mapped CPU port.
// The receiver pushes bytes with a one-cycle strobe. The CPU reads the head at
// DATA_ADDR, and the byte is popped when the load completes. STAT_ADDR holds
// the status and control bits: {4'b0, irq_en, overrun, full, nonempty}.
module rx_fifo #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] DATA_ADDR = 8'd252,
    parameter logic [7:0] STAT_ADDR = 8'd251
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [7:0] addr,
    input  logic       reg_w_en,
    input  logic       mem_w_en,
    input  logic [7:0] w_data,
    input  logic       int_en,
    output logic [7:0] r_data,
    output logic       hit,
    output logic       int_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overrun;
    logic          irq_en;

    logic full;
    logic nonempty;
    logic data_sel;
    logic stat_sel;
    logic do_pop;
    logic do_push;
    logic overflow;
    logic stat_wr;

    // Only w_data[3] (irq_en) and w_data[2] (overrun clear) are meaningful.
    logic unused_wdata;
    assign unused_wdata = ^{w_data[7:4], w_data[1:0]};

    assign full     = (count == FULL_CNT);
    assign nonempty = (count != '0);
    assign data_sel = (addr == DATA_ADDR);
    assign stat_sel = (addr == STAT_ADDR);
    assign hit      = data_sel | stat_sel;

    // A pop on an empty FIFO is ignored. A pop while full frees the slot for a
    // same-cycle push, so that push is accepted and does not count as overrun.
    assign do_pop   = data_sel & reg_w_en & nonempty;
    assign do_push  = rx_valid & (~full | do_pop);
    assign overflow = rx_valid & full & ~do_pop;
    assign stat_wr  = mem_w_en & stat_sel;

    // Storage is written without reset; the pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Control register: irq_en load, plus overrun set/clear. A same-cycle overflow beats the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (stat_wr) begin
                irq_en <= w_data[3];
            end
            if (overflow) begin
                overrun <= 1'b1;
            end else if (stat_wr && w_data[2]) begin
                overrun <= 1'b0;
            end
        end
    end

    // Level interrupt, registered one cycle behind its qualifying condition.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int_req <= 1'b0;
        end else begin
            int_req <= irq_en & int_en & nonempty;
        end
    end

    // CPU read mux: the head byte at DATA_ADDR, status at STAT_ADDR, zero elsewhere.
    always_comb begin
        r_data = 8'h00;
        if (data_sel) begin
            r_data = nonempty ? mem[rd_ptr] : 8'h00;
        end else if (stat_sel) begin
            r_data = {4'b0000, irq_en, overrun, full, nonempty};
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed scoreboard bench for rx_fifo (DEPTH=8).
// The stimulus pushes expected values into a queue. The monitor pops and
// compares them on the falling edge of each cycle that the stimulus marked.
module tb_rx_fifo;

    localparam logic [7:0] DA = 8'd252;
    localparam logic [7:0] SA = 8'd251;
    localparam int K_RDATA = 0;
    localparam int K_IRQ   = 1;
    localparam int K_HIT   = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] addr = 8'h00;
    logic       reg_w_en = 1'b0;
    logic       mem_w_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       int_en = 1'b0;
    logic [7:0] r_data;
    logic       hit;
    logic       int_req;

    typedef struct {
        int         kind;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   chk_n = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    rx_fifo #(.DEPTH(8), .DATA_ADDR(DA), .STAT_ADDR(SA)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .addr     (addr),
        .reg_w_en (reg_w_en),
        .mem_w_en (mem_w_en),
        .w_data   (w_data),
        .int_en   (int_en),
        .r_data   (r_data),
        .hit      (hit),
        .int_req  (int_req)
    );

    always #5 clock = ~clock;

    // Monitor: on marked cycles, pop one expectation per requested check and compare.
    always @(negedge clock) begin
        for (int i = 0; i < chk_n; i++) begin
            exp_t e;
            logic [7:0] act;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got no expectation, required one");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_IRQ:   act = {7'b0, int_req};
                    K_HIT:   act = {7'b0, hit};
                    default: act = r_data;
                endcase
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", e.nm, act, e.val);
                end
            end
        end
    end

    // One bus cycle: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic rv, input logic [7:0] rb, input logic [7:0] a,
                         input logic rw, input logic mw, input logic [7:0] wd);
        @(posedge clock);
        #1;
        chk_n    = 0;
        rx_valid = rv;
        rx_byte  = rb;
        addr     = a;
        reg_w_en = rw;
        mem_w_en = mw;
        w_data   = wd;
    endtask

    task automatic exp_v(input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.nm   = nm;
        sb.push_back(e);
        chk_n++;
    endtask

    task automatic idle();                      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00); endtask
    task automatic push(input logic [7:0] b);   drive(1'b1, b,     8'h00, 1'b0, 1'b0, 8'h00); endtask
    task automatic rd_data(input logic [7:0] v);
        drive(1'b0, 8'h00, DA, 1'b1, 1'b0, 8'h00);
        exp_v(K_RDATA, v, "data");
    endtask
    task automatic rd_stat(input logic [7:0] v);
        drive(1'b0, 8'h00, SA, 1'b0, 1'b0, 8'h00);
        exp_v(K_RDATA, v, "status");
    endtask
    task automatic st_stat(input logic [7:0] wd); drive(1'b0, 8'h00, SA, 1'b0, 1'b1, wd); endtask

    initial begin
        // Reset state, checked while reset is still asserted.
        drive(1'b0, 8'h00, SA, 1'b0, 1'b0, 8'h00);
        exp_v(K_RDATA, 8'h00, "reset_status");
        exp_v(K_IRQ,   8'h00, "reset_int_req");
        exp_v(K_HIT,   8'h01, "hit_stat");
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 8'h00);
        exp_v(K_RDATA, 8'h00, "other_addr_rdata");
        exp_v(K_HIT,   8'h00, "hit_other");
        drive(1'b0, 8'h00, DA, 1'b0, 1'b0, 8'h00);
        exp_v(K_HIT,   8'h01, "hit_data");
        exp_v(K_RDATA, 8'h00, "empty_data");

        // Ordering: 41,42,43 in, then the same bytes out, then empty status.
        push(8'h41); push(8'h42); push(8'h43);
        rd_data(8'h41); rd_data(8'h42); rd_data(8'h43);
        rd_stat(8'h00);

        // Fill plus one overflow: overrun, full and nonempty are all set.
        for (int i = 0; i < 9; i++) push(8'(i));
        rd_stat(8'h07);
        for (int i = 0; i < 8; i++) rd_data(8'(i));
        rd_stat(8'h04);
        rd_data(8'h00);
        rd_stat(8'h04);
        st_stat(8'h04);
        rd_stat(8'h00);

        // Push and pop together while full: accepted, no overrun, order kept.
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        rd_stat(8'h03);
        drive(1'b1, 8'h18, DA, 1'b1, 1'b0, 8'h00);
        exp_v(K_RDATA, 8'h10, "full_pushpop");
        rd_stat(8'h03);
        drive(1'b1, 8'h19, DA, 1'b1, 1'b0, 8'h00);
        exp_v(K_RDATA, 8'h11, "full_pushpop");
        rd_stat(8'h03);
        for (int i = 0; i < 8; i++) rd_data(8'(8'h12 + i));
        rd_stat(8'h00);

        // Push and pop together while empty: only the push takes effect.
        drive(1'b1, 8'hA5, DA, 1'b1, 1'b0, 8'h00);
        exp_v(K_RDATA, 8'h00, "empty_pushpop");
        rd_stat(8'h01);
        rd_data(8'hA5);
        rd_stat(8'h00);

        // Overrun clear races a same-cycle overflow; the overflow wins.
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        drive(1'b1, 8'h28, SA, 1'b0, 1'b1, 8'h04);
        rd_stat(8'h07);
        st_stat(8'h04);
        rd_stat(8'h03);
        for (int i = 0; i < 8; i++) rd_data(8'(8'h20 + i));
        rd_stat(8'h00);

        // Interrupts: the request follows nonempty one cycle late.
        int_en = 1'b1;
        st_stat(8'h08);
        push(8'h55);
        exp_v(K_IRQ, 8'h00, "irq_before_push");
        rd_stat(8'h09);
        exp_v(K_IRQ, 8'h00, "irq_lag");
        idle();
        exp_v(K_IRQ, 8'h01, "irq_set");
        rd_data(8'h55);
        exp_v(K_IRQ, 8'h01, "irq_hold");
        idle();
        exp_v(K_IRQ, 8'h01, "irq_lag_pop");
        idle();
        exp_v(K_IRQ, 8'h00, "irq_clear");
        int_en = 1'b0;
        push(8'h66);
        idle();
        idle();
        exp_v(K_IRQ, 8'h00, "irq_masked");
        idle();
        exp_v(K_IRQ, 8'h00, "irq_masked");

        // Reset mid-fill: five bytes queued with the interrupt active.
        int_en = 1'b1;
        for (int i = 1; i < 5; i++) push(8'(i));
        idle();
        idle();
        exp_v(K_IRQ, 8'h01, "irq_pre_reset");
        rd_stat(8'h09);
        idle();
        reset_n = 1'b0;
        drive(1'b0, 8'h00, SA, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        exp_v(K_RDATA, 8'h00, "post_reset_status");
        exp_v(K_IRQ,   8'h00, "post_reset_irq");
        rd_data(8'h00);
        push(8'h77);
        rd_data(8'h77);
        rd_stat(8'h00);

        idle();
        idle();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
